bus_fabric: RTL and testbench
=============================

Name: bus_fabric

Overview:
- Parametrised single-master, N-slave bus router between the criscv core and its memory-mapped targets: on-chip RAM, SDRAM and peripherals.
- Replaces the hard-coded combinational address mux in the top level.
- Adds the following, none of which the old mux has:
  - a registered slave select that is latched for the whole transaction;
  - priority-ordered base/mask region decode;
  - an error response for unmapped addresses;
  - a per-transaction timeout watchdog;
  - a sticky bus-error flag.
- The broadcast signals (rw, write_data, size) stay shared wires outside this block.

Parameters:
- NSLAVE, 3: number of slave ports (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BASE_VEC, {32'h80000000, 32'h00000000, 32'h00000000}: flattened region bases; slave i uses bits [i*ADDR_W +: ADDR_W].
- MASK_VEC, {32'h80000000, 32'h80000000, 32'hFFFF0000}: flattened region masks. Slave i matches when (address & mask_i) == base_i.
- TIMEOUT, 1023: cycles allowed in BUSY before the watchdog fires. Valid range 1..65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on an error response.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_address  in  ADDR_W  master address, held stable while m_rw_req is high
- m_rw_req  in  1  master request, level; held until m_rec
- m_read_data  out  DATA_W  read data to master
- m_rec  out  1  one-cycle completion pulse to master
- s_rw_req  out  NSLAVE  per-slave request, one-hot or zero
- s_read_data  in  NSLAVE*DATA_W  flattened slave read data
- s_rec  in  NSLAVE  per-slave completion
- bus_err  out  1  sticky error flag
- err_clear  in  1  clears bus_err and the capture registers
- err_addr  out  ADDR_W  captured faulting address (optional feature)
- err_cause  out  2  00 none, 01 unmapped, 10 timeout (optional feature)

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE; sel_q=0; timer=0;
  - all outputs 0: m_rec, m_read_data, s_rw_req, bus_err, err_addr, err_cause.
  - Reset mid-transaction aborts it silently, with no m_rec.
- Decode:
  - Combinational over all regions; the lowest index that matches wins.
  - With the defaults: 0x0000_0000..0x0000_FFFF goes to slave 0, remaining addresses below 0x8000_0000 go to slave 1, and 0x8000_0000 and above go to slave 2.
- States:
  - IDLE:
    - m_rw_req=1 and a match: latch sel_q, clear timer, go to BUSY.
    - m_rw_req=1 and no match: go to ERR.
  - BUSY:
    - s_rw_req[sel_q] = m_rw_req; all other bits 0. Timer increments each cycle.
    - s_rec[sel_q]=1: m_rec=1 and m_read_data = s_read_data[sel_q], both registered (1-cycle latency after s_rec). Go to DONE.
    - timer == TIMEOUT-1 with no s_rec: drop s_rw_req, set bus_err, cause=10. Go to ERR.
    - m_rw_req drops (abort): go to IDLE with no m_rec.
    - s_rec on an unselected slave is ignored.
    - s_rec and timer expiry in the same cycle: s_rec wins.
  - ERR:
    - m_rec=1 and m_read_data=ERR_DATA for exactly one cycle. Go to DONE.
    - For the unmapped case, also set bus_err and cause=01.
  - DONE:
    - s_rw_req=0, m_rec=0. Wait for m_rw_req=0, then go to IDLE.
    - This prevents a held request re-triggering the slave.
- m_read_data holds its last value outside m_rec cycles.
- Minimum transaction is 4 cycles: IDLE, BUSY, response, DONE.
- Error flag:
  - bus_err stays set until err_clear=1.
  - err_clear and a new error in the same cycle: the error wins.
- Writes to unmapped addresses complete with m_rec; ERR_DATA is ignored by the master.

Optional Feature:
- BUS_FABRIC_ERR_CAPTURE_EN.
- Defined:
  - On the first error while bus_err=0, err_addr latches m_address and err_cause latches the cause.
  - Later errors do not overwrite them until err_clear.
- Undefined:
  - err_addr and err_cause are tied to 0.
  - bus_err still operates.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding: IDLE=0, BUSY=1, ERR=2, DONE=3;
  - cause codes;
  - default ERR_DATA;
  - default memory-map constants: RAM_BASE, RAM_MASK, SDRAM_BASE, SDRAM_MASK, PER_BASE, PER_MASK.
- One sub-module: bus_region_decode. It is combinational: from address, BASE_VEC and MASK_VEC it produces hit and idx with priority encoding. It can be reused by a future multi-master arbiter.

Test Plan:
- Read 0x0000_0010 with slave0 s_rec after 2 cycles returning 0x12345678 -> s_rw_req=3'b001, m_rec one cycle later with data 0x12345678, bus_err=0.
- Address 0x0001_0000 -> s_rw_req=3'b010. Address 0x8000_0004 -> s_rw_req=3'b100. Overlapping regions resolve to the lowest index.
- Remap MASK_VEC so that 0x8000_0000 is unmapped, then request it -> no s_rw_req, m_rec with 0xDEADBEEF, bus_err=1, err_cause=01, err_addr=0x8000_0000 (with BUS_FABRIC_ERR_CAPTURE_EN).
- TIMEOUT=8 and a slave that never responds -> s_rw_req drops after 8 cycles, m_rec with ERR_DATA, err_cause=10. A second error does not overwrite the capture. err_clear zeroes all three error outputs.
- m_rw_req held 5 cycles after m_rec -> no second s_rw_req. Spurious s_rec[0] while slave1 is selected -> ignored.
- Reset asserted in BUSY -> all outputs 0 immediately. After release, a new request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the criscv bus fabric: FSM encoding, error
// cause codes, default error read data and the default memory map.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } bus_cause_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] SDRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] SDRAM_MASK = 32'h8000_0000;
  localparam logic [31:0] PER_BASE   = 32'h8000_0000;
  localparam logic [31:0] PER_MASK   = 32'h8000_0000;

  // Slave index width; a single-slave fabric still carries a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Priority base/mask region decoder: the lowest-numbered matching region wins.
// Purely combinational so it can be shared by a future multi-master arbiter.
module bus_region_decode
  import bus_pkg::*;
#(
  parameter int                         NSLAVE   = 3,
  parameter int                         ADDR_W   = 32,
  parameter logic [NSLAVE*ADDR_W-1:0]   BASE_VEC = {PER_BASE, SDRAM_BASE, RAM_BASE},
  parameter logic [NSLAVE*ADDR_W-1:0]   MASK_VEC = {PER_MASK, SDRAM_MASK, RAM_MASK},
  localparam int                        IDX_W    = idx_width(NSLAVE)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan from the top down so a lower index overwrites any higher match.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((addr_i & MASK_VEC[i*ADDR_W +: ADDR_W]) == BASE_VEC[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, N-slave bus router with latched slave select, unmapped and
// timeout error responses and a sticky bus_err. Optional BUS_FABRIC_ERR_CAPTURE_EN
// adds first-error address/cause capture; otherwise err_addr/err_cause read 0.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                         NSLAVE   = 3,
  parameter int                         ADDR_W   = 32,
  parameter int                         DATA_W   = 32,
  parameter logic [NSLAVE*ADDR_W-1:0]   BASE_VEC = {PER_BASE, SDRAM_BASE, RAM_BASE},
  parameter logic [NSLAVE*ADDR_W-1:0]   MASK_VEC = {PER_MASK, SDRAM_MASK, RAM_MASK},
  parameter int                         TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0]          ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        m_address,
  input  logic                     m_rw_req,
  output logic [DATA_W-1:0]        m_read_data,
  output logic                     m_rec,
  output logic [NSLAVE-1:0]        s_rw_req,
  input  logic [NSLAVE*DATA_W-1:0] s_read_data,
  input  logic [NSLAVE-1:0]        s_rec,
  output logic                     bus_err,
  input  logic                     err_clear,
  output logic [ADDR_W-1:0]        err_addr,
  output logic [1:0]               err_cause,
  output logic [1:0]               dbg_state
);

  localparam int          IDX_W    = idx_width(NSLAVE);
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

  bus_state_e          state_q, state_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [15:0]         timer_q, timer_d;
  logic                m_rec_q, m_rec_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                err_set;
  bus_cause_e          err_code;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                sel_rec;
  logic [DATA_W-1:0]   sel_rdata;

  bus_region_decode #(
    .NSLAVE   (NSLAVE),
    .ADDR_W   (ADDR_W),
    .BASE_VEC (BASE_VEC),
    .MASK_VEC (MASK_VEC)
  ) u_decode (
    .addr_i (m_address),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_rec   = s_rec[sel_q];
  assign sel_rdata = s_read_data[int'(sel_q)*DATA_W +: DATA_W];

  // Handshake: m_rw_req is a level held until the one-cycle m_rec pulse; the
  // selected s_rw_req mirrors it while BUSY, and DONE waits for the master to
  // drop its request so a held request cannot re-trigger the slave.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    m_rec_d  = 1'b0;
    rdata_d  = rdata_q;
    s_rw_req = '0;
    err_set  = 1'b0;
    err_code = CAUSE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (m_rw_req) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            timer_d = '0;
            state_d = ST_BUSY;
          end else begin
            err_set  = 1'b1;
            err_code = CAUSE_UNMAPPED;
            state_d  = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        s_rw_req[sel_q] = m_rw_req;
        timer_d         = timer_q + 16'd1;
        if (!m_rw_req) begin
          state_d = ST_IDLE;
        end else if (sel_rec) begin
          m_rec_d = 1'b1;
          rdata_d = sel_rdata;
          state_d = ST_DONE;
        end else if (timer_q == TMR_LAST) begin
          err_set  = 1'b1;
          err_code = CAUSE_TIMEOUT;
          state_d  = ST_ERR;
        end
      end
      ST_ERR: begin
        m_rec_d = 1'b1;
        rdata_d = ERR_DATA;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!m_rw_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new error outranks a simultaneous clear.
  assign bus_err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : bus_err_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      timer_q   <= '0;
      m_rec_q   <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      m_rec_q   <= m_rec_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [1:0]        err_cause_q, err_cause_d;

  always_comb begin
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    if (err_set && (!bus_err_q || err_clear)) begin
      err_addr_d  = m_address;
      err_cause_d = err_code;
    end else if (err_clear) begin
      err_addr_d  = '0;
      err_cause_d = CAUSE_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else begin
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;
`else
  assign err_addr  = '0;
  assign err_cause = CAUSE_NONE;
`endif

  assign m_rec       = m_rec_q;
  assign m_read_data = rdata_q;
  assign bus_err     = bus_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed vector table, hand-written error/abort/reset
// sequences and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_fabric;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int NEVER = 255;
  localparam logic [DW-1:0] ERRD = 32'hDEAD_BEEF;
  // Slave 2 is moved to 0xC000_0000 so 0x8000_0000..0xBFFF_FFFF is unmapped.
  localparam logic [NS*AW-1:0] BASES = {32'hC000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hC000_0000, 32'h8000_0000, 32'hFFFF_0000};
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     m_address;
  logic              m_rw_req;
  logic [DW-1:0]     m_read_data;
  logic              m_rec;
  logic [NS-1:0]     s_rw_req;
  logic [NS*DW-1:0]  s_read_data;
  logic [NS-1:0]     s_rec;
  logic              bus_err;
  logic              err_clear;
  logic [AW-1:0]     err_addr;
  logic [1:0]        err_cause;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  bus_fabric #(
    .NSLAVE(NS), .ADDR_W(AW), .DATA_W(DW),
    .BASE_VEC(BASES), .MASK_VEC(MASKS),
    .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_rw_req(m_rw_req),
    .m_read_data(m_read_data), .m_rec(m_rec),
    .s_rw_req(s_rw_req), .s_read_data(s_read_data), .s_rec(s_rec),
    .bus_err(bus_err), .err_clear(err_clear),
    .err_addr(err_addr), .err_cause(err_cause),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            delay;
    logic [DW-1:0] data;
    int            hold;
    logic [NS-1:0] req_mask;
    int            req_cycles;
    int            rec_cycle;
    logic [DW-1:0] rdata;
    logic          bus_err;
    logic [1:0]    cause;
    logic [AW-1:0] eaddr;
  } vec_t;

  typedef struct {
    logic [NS-1:0] req_mask;
    int            req_cycles;
    int            rec_cycle;
    int            rec_count;
    logic [DW-1:0] rdata;
    logic          hold_ok;
    logic          bus_err;
    logic [1:0]    cause;
    logic [AW-1:0] eaddr;
  } obs_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] m_base [NS] = '{32'h0000_0000, 32'h0000_0000, 32'hC000_0000};
  logic [AW-1:0] m_mask [NS] = '{32'hFFFF_0000, 32'h8000_0000, 32'hC000_0000};
  logic          exp_err;
  logic [1:0]    exp_cause;
  logic [AW-1:0] exp_eaddr;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    exp_err   = 1'b0;
    exp_cause = 2'b00;
    exp_eaddr = '0;
  endtask

  // Transaction-level prediction from the address map, slave latency and timeout.
  task automatic predict(input logic [AW-1:0] addr, input int delay, input logic [DW-1:0] data,
                         input logic clr, output vec_t e);
    int s;
    logic err;
    logic [1:0] c;
    s = decode(addr);
    err = 1'b0;
    c = 2'b00;
    e.addr = addr; e.delay = delay; e.data = data; e.hold = 0;
    if (clr) model_clear();
    if (s < 0) begin
      e.req_mask = '0; e.req_cycles = 0; e.rec_cycle = 2; e.rdata = ERRD;
      err = 1'b1; c = 2'b01;
    end else if (delay <= TO) begin
      e.req_mask = NS'(1) << s; e.req_cycles = delay; e.rec_cycle = delay + 1; e.rdata = data;
    end else begin
      e.req_mask = NS'(1) << s; e.req_cycles = TO; e.rec_cycle = TO + 2; e.rdata = ERRD;
      err = 1'b1; c = 2'b10;
    end
    if (err) begin
      if (!exp_err && CAP_EN) begin
        exp_cause = c;
        exp_eaddr = addr;
      end
      exp_err = 1'b1;
    end
    e.bus_err = exp_err; e.cause = exp_cause; e.eaddr = exp_eaddr;
  endtask

  // Master issues one request; the bench acts as the slave, answering after
  // `delay` request cycles and sprinkling s_rec on unrequested slaves.
  task automatic run_txn(input logic [AW-1:0] addr, input int delay, input logic [DW-1:0] data,
                         input int hold, input logic clr_first, output obs_t o);
    logic done;
    o.req_mask = '0; o.req_cycles = 0; o.rec_cycle = 0; o.rec_count = 0;
    o.rdata = '0; o.hold_ok = 1'b1; o.bus_err = 1'b0; o.cause = 2'b00; o.eaddr = '0;
    done = 1'b0;
    @(negedge clk);
    m_address = addr;
    m_rw_req  = 1'b1;
    err_clear = clr_first;
    s_rec     = '0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      err_clear   = 1'b0;
      s_rec       = '0;
      s_read_data = {$urandom, $urandom, $urandom};
      #1;
      if (s_rw_req != '0) o.req_cycles++;
      o.req_mask |= s_rw_req;
      if (m_rec) begin
        o.rec_count++;
        if (o.rec_cycle == 0) begin
          o.rec_cycle = cyc;
          o.rdata     = m_read_data;
        end
      end
      if (o.rec_cycle != 0 && cyc > o.rec_cycle && (s_rw_req != '0 || m_read_data !== o.rdata))
        o.hold_ok = 1'b0;
      if (o.rec_cycle != 0 && cyc >= o.rec_cycle + hold) done = 1'b1;
      if ($urandom_range(0, 3) == 0) s_rec = NS'($urandom) & ~s_rw_req;
      if (s_rw_req != '0 && o.req_cycles == delay) begin
        s_rec = s_rec | s_rw_req;
        for (int i = 0; i < NS; i++)
          if (s_rw_req[i]) s_read_data[i*DW +: DW] = data;
      end
    end
    @(negedge clk);
    m_rw_req = 1'b0;
    s_rec    = '0;
    @(negedge clk);
    #1;
    if (m_rec) o.rec_count++;
    if (m_read_data !== o.rdata) o.hold_ok = 1'b0;
    o.bus_err = bus_err;
    o.cause   = err_cause;
    o.eaddr   = err_addr;
  endtask

  task automatic compare(input string tag, input obs_t o, input vec_t e);
    check({tag, " req_mask"},   64'(o.req_mask),   64'(e.req_mask));
    check({tag, " req_cycles"}, 64'(o.req_cycles), 64'(e.req_cycles));
    check({tag, " rec_cycle"},  64'(o.rec_cycle),  64'(e.rec_cycle));
    check({tag, " rec_count"},  64'(o.rec_count),  64'd1);
    check({tag, " rdata"},      64'(o.rdata),      64'(e.rdata));
    check({tag, " hold"},       64'(o.hold_ok),    64'd1);
    check({tag, " bus_err"},    64'(o.bus_err),    64'(e.bus_err));
    check({tag, " err_cause"},  64'(o.cause),      64'(e.cause));
    check({tag, " err_addr"},   64'(o.eaddr),      64'(e.eaddr));
  endtask

  task automatic do_txn(input string tag, input logic [AW-1:0] addr, input int delay,
                        input int hold, input logic clr);
    vec_t e;
    obs_t o;
    logic [DW-1:0] data;
    data = $urandom;
    predict(addr, delay, data, clr, e);
    run_txn(addr, delay, data, hold, clr, o);
    compare(tag, o, e);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    model_clear();
    #1;
    check("clear bus_err",   64'(bus_err),   64'd0);
    check("clear err_cause", 64'(err_cause), 64'd0);
    check("clear err_addr",  64'(err_addr),  64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " s_rw_req"},    64'(s_rw_req),    64'd0);
    check({tag, " m_rec"},       64'(m_rec),       64'd0);
    check({tag, " m_read_data"}, 64'(m_read_data), 64'd0);
    check({tag, " bus_err"},     64'(bus_err),     64'd0);
    check({tag, " err_cause"},   64'(err_cause),   64'd0);
    check({tag, " err_addr"},    64'(err_addr),    64'd0);
    check({tag, " state"},       64'(dbg_state),   64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl [6];
    obs_t o;
    logic [AW-1:0] a;
    int k;

    tbl[0] = '{32'h0000_0010, 2, 32'h1234_5678, 5, 3'b001, 2, 3, 32'h1234_5678, 1'b0, 2'b00, '0};
    tbl[1] = '{32'h0001_0000, 1, 32'hA5A5_0001, 0, 3'b010, 1, 2, 32'hA5A5_0001, 1'b0, 2'b00, '0};
    tbl[2] = '{32'hC000_0004, 3, 32'h0BAD_F00D, 2, 3'b100, 3, 4, 32'h0BAD_F00D, 1'b0, 2'b00, '0};
    tbl[3] = '{32'h0000_FFFC, 8, 32'h1111_2222, 1, 3'b001, 8, 9, 32'h1111_2222, 1'b0, 2'b00, '0};
    tbl[4] = '{32'h7FFF_FFFC, 1, 32'h3333_4444, 3, 3'b010, 1, 2, 32'h3333_4444, 1'b0, 2'b00, '0};
    tbl[5] = '{32'hFFFF_FFFF, 5, 32'h5555_6666, 4, 3'b100, 5, 6, 32'h5555_6666, 1'b0, 2'b00, '0};

    reset = 1'b0; m_address = '0; m_rw_req = 1'b0; s_read_data = '0; s_rec = '0; err_clear = 1'b0;
    model_clear();
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].addr, tbl[i].delay, tbl[i].data, tbl[i].hold, 1'b0, o);
      compare($sformatf("vec%0d", i), o, tbl[i]);
    end

    do_txn("unmapped", 32'h8000_0000, 1, 1, 1'b0);
    do_txn("timeout_2nd", 32'h0000_0100, NEVER, 0, 1'b0);
    pulse_clear();
    do_txn("timeout", 32'h0001_2340, NEVER, 2, 1'b0);
    do_txn("err_vs_clear", 32'h9000_0008, 1, 0, 1'b1);
    pulse_clear();

    // Abort: master withdraws while BUSY; no completion may follow.
    @(negedge clk);
    m_address = 32'h0001_0000;
    m_rw_req  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("abort s_rw_req", 64'(s_rw_req), 64'b010);
    m_rw_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("abort m_rec", 64'(m_rec), 64'd0);
    end
    check("abort state", 64'(dbg_state), 64'd0);
    do_txn("after_abort", 32'h0000_0040, 2, 0, 1'b0);

    // Reset while BUSY after an error has left state behind.
    do_txn("pre_reset_err", 32'h8000_1000, 1, 0, 1'b0);
    @(negedge clk);
    m_address = 32'h0000_0010;
    m_rw_req  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_busy");
    m_rw_req = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_reset m_rec", 64'(m_rec), 64'd0);
    end
    do_txn("after_reset", 32'h0000_0010, 2, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = $urandom & 32'h7FFF_FFFF;
        2:       a = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
        default: a = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
      endcase
      do_txn($sformatf("rnd%0d", n), a, $urandom_range(1, 11), $urandom_range(0, 5),
             1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) pulse_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
